// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: latches jump/dead/win event pulses, grants them by
// fixed priority and paces each effect and its trailing silence in sample ticks.
module sfx_scheduler #(
    parameter int CNT_W     = 20,
    parameter int JUMP_LEN  = 12000,
    parameter int DEAD_LEN  = 48000,
    parameter int WIN_LEN   = 96000,
    parameter int GAP_TICKS = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic       jump_req,
    input  logic       dead_req,
    input  logic       win_req,
    input  logic       mute,
    output logic [1:0] audio_select,
    output logic       play_start,
    output logic       busy,
    output logic [2:0] pending
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_JUMP = 2'd1;
    localparam logic [1:0] ID_DEAD = 2'd2;
    localparam logic [1:0] ID_WIN  = 2'd3;

    localparam logic [CNT_W-1:0] JUMP_LAST = CNT_W'(JUMP_LEN - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_LEN - 1);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       id_q, id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pending_q, pending_d;
    logic [2:0]       grantClr;
    logic [1:0]       topId;
    logic [2:0]       topMask;

    function automatic logic [CNT_W-1:0] lastCount(input logic [1:0] id);
        logic [CNT_W-1:0] result;
        case (id)
            ID_DEAD: result = DEAD_LAST;
            ID_WIN:  result = WIN_LAST;
            default: result = JUMP_LAST;
        endcase
        return result;
    endfunction

    // Effect ids are numbered in priority order, so the highest pending bit is also the largest id.
    always_comb begin
        topId   = ID_NONE;
        topMask = 3'b000;
        if (pending_q[2]) begin
            topId   = ID_WIN;
            topMask = 3'b100;
        end else if (pending_q[1]) begin
            topId   = ID_DEAD;
            topMask = 3'b010;
        end else if (pending_q[0]) begin
            topId   = ID_JUMP;
            topMask = 3'b001;
        end
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        grantClr = 3'b000;
        if (mute) begin
            state_d = ST_IDLE;
            id_d    = ID_NONE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (topId != ID_NONE) begin
                        state_d  = ST_START;
                        id_d     = topId;
                        grantClr = topMask;
                    end
                end
                ST_START: begin
                    cnt_d   = lastCount(id_q);
                    state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    // A strictly higher-priority request restarts playback; the interrupted effect is dropped.
                    if (topId > id_q) begin
                        state_d  = ST_START;
                        id_d     = topId;
                        grantClr = topMask;
                    end else if (sample_tick) begin
                        if (cnt_q == CNT_ZERO) begin
                            if (GAP_TICKS == 0) begin
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_GAP;
                                cnt_d   = GAP_LAST;
                            end
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                ST_GAP: begin
                    if (sample_tick) begin
                        if (cnt_q == CNT_ZERO) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // A request arriving in the same cycle as its grant survives, so it plays once more afterwards.
    always_comb begin
        pending_d = ((pending_q & ~grantClr) | {win_req, dead_req, jump_req});
        if (mute) begin
            pending_d = 3'b000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            id_q      <= ID_NONE;
            cnt_q     <= CNT_ZERO;
            pending_q <= 3'b000;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign audio_select = ((state_q == ST_START) || (state_q == ST_PLAY)) ? id_q : ID_NONE;
    assign play_start   = (state_q == ST_START);
    assign busy         = (state_q != ST_IDLE);
    assign pending      = pending_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: request-combination table plus hand-written preemption,
// coalescing, mute and async-reset sequences, all checked through a play scoreboard.
module tb_sfx_scheduler;

    localparam int CNT_W     = 20;
    localparam int JUMP_LEN  = 4;
    localparam int DEAD_LEN  = 6;
    localparam int WIN_LEN   = 8;
    localparam int GAP_TICKS = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_tick;
    logic       jump_req;
    logic       dead_req;
    logic       win_req;
    logic       mute;
    logic [1:0] audio_select;
    logic       play_start;
    logic       busy;
    logic [2:0] pending;

    sfx_scheduler #(
        .CNT_W    (CNT_W),
        .JUMP_LEN (JUMP_LEN),
        .DEAD_LEN (DEAD_LEN),
        .WIN_LEN  (WIN_LEN),
        .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .jump_req    (jump_req),
        .dead_req    (dead_req),
        .win_req     (win_req),
        .mute        (mute),
        .audio_select(audio_select),
        .play_start  (play_start),
        .busy        (busy),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int ticks;
    } play_t;

    typedef struct {
        logic [2:0] req;
        logic [2:0] expPending;
        logic [1:0] expFirst;
        logic [2:0] expAfterGrant;
    } vec_t;

    play_t sbQ[$];
    vec_t  vecs[7];

    int tests = 0;
    int fails = 0;
    int phase = 0;
    int curId = 0;
    int playTicks = 0;
    int gapTicks = 0;
    int inGap = 0;
    int starts = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic finalizePlay(input int obsId, input int obsTicks);
        play_t e;
        if (sbQ.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpectedPlay: got id %0d, expected no play", obsId);
        end else begin
            e = sbQ.pop_front();
            checkOutput("playId", obsId, e.id);
            if (e.ticks >= 0) begin
                checkOutput("playTicks", obsTicks, e.ticks);
            end
        end
    endtask

    // One clock: drive the tick, advance, then track plays and gaps from what the DUT showed.
    task automatic cycle();
        logic [1:0] pA;
        logic       pS, pB, pT;
        sample_tick = (phase == 3);
        phase = (phase + 1) % 4;
        pA = audio_select;
        pS = play_start;
        pB = busy;
        pT = sample_tick;
        @(posedge clk);
        #1;
        if (pB && pA != 2'd0 && !pS && pT) playTicks++;
        if (pB && pA == 2'd0 && pT && inGap != 0) gapTicks++;
        if (play_start) begin
            starts++;
            if (curId != 0) finalizePlay(curId, playTicks);
            curId = int'(audio_select);
            playTicks = 0;
        end else if (curId != 0 && audio_select == 2'd0) begin
            finalizePlay(curId, playTicks);
            curId = 0;
            if (busy) begin
                inGap = 1;
                gapTicks = 0;
            end
        end
        if (pB && !busy && inGap != 0) begin
            checkOutput("gapTicks", gapTicks, GAP_TICKS);
            inGap = 0;
        end
    endtask

    task automatic applyStimulus(input logic [2:0] req);
        {win_req, dead_req, jump_req} = req;
        cycle();
        {win_req, dead_req, jump_req} = 3'b000;
    endtask

    task automatic waitIdle();
        bit done = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy && pending == 3'b000) begin
                done = 1;
                break;
            end
            cycle();
        end
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL waitIdle: got busy=%0d pending=%0d, expected idle within 400 cycles", busy, pending);
        end
        checkOutput("scoreboardEmpty", sbQ.size(), 0);
    endtask

    task automatic waitPlayTicks(input int id, input int n);
        bit done = 0;
        for (int i = 0; i < 100; i++) begin
            if (curId == id && playTicks >= n) begin
                done = 1;
                break;
            end
            cycle();
        end
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL waitPlayTicks: got id %0d ticks %0d, expected id %0d ticks %0d", curId, playTicks, id, n);
        end
    endtask

    task automatic runSingleJump();
        sbQ.push_back('{id: 1, ticks: JUMP_LEN});
        applyStimulus(3'b001);
        checkOutput("jumpPendingSet", int'(pending), 1);
        checkOutput("jumpNoEarlyStart", int'(play_start), 0);
        cycle();
        checkOutput("jumpPlayStart", int'(play_start), 1);
        checkOutput("jumpSelectAtStart", int'(audio_select), 1);
        checkOutput("jumpBusyAtStart", int'(busy), 1);
        checkOutput("jumpPendingCleared", int'(pending), 0);
        cycle();
        checkOutput("jumpStartPulseEnds", int'(play_start), 0);
        checkOutput("jumpSelectHeld", int'(audio_select), 1);
        waitIdle();
        checkOutput("jumpBusyEnd", int'(busy), 0);
    endtask

    initial begin
        assert (WIN_LEN >= 1 && WIN_LEN <= (1 << CNT_W));
        assert (DEAD_LEN >= 1 && DEAD_LEN <= (1 << CNT_W));
        assert (JUMP_LEN >= 1 && JUMP_LEN <= (1 << CNT_W));
        assert (GAP_TICKS <= (1 << CNT_W));

        vecs[0] = '{3'b001, 3'b001, 2'b01, 3'b000};
        vecs[1] = '{3'b010, 3'b010, 2'b10, 3'b000};
        vecs[2] = '{3'b011, 3'b011, 2'b10, 3'b001};
        vecs[3] = '{3'b100, 3'b100, 2'b11, 3'b000};
        vecs[4] = '{3'b101, 3'b101, 2'b11, 3'b001};
        vecs[5] = '{3'b110, 3'b110, 2'b11, 3'b010};
        vecs[6] = '{3'b111, 3'b111, 2'b11, 3'b011};

        reset = 1'b1;
        sample_tick = 1'b0;
        jump_req = 1'b0;
        dead_req = 1'b0;
        win_req = 1'b0;
        mute = 1'b0;
        #1;
        checkOutput("resetSelect", int'(audio_select), 0);
        checkOutput("resetPlayStart", int'(play_start), 0);
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetPending", int'(pending), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();

        $display("[TB] single jump");
        runSingleJump();

        $display("[TB] request combination table");
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].req[2]) sbQ.push_back('{id: 3, ticks: WIN_LEN});
            if (vecs[v].req[1]) sbQ.push_back('{id: 2, ticks: DEAD_LEN});
            if (vecs[v].req[0]) sbQ.push_back('{id: 1, ticks: JUMP_LEN});
            applyStimulus(vecs[v].req);
            checkOutput("tablePending", int'(pending), int'(vecs[v].expPending));
            cycle();
            checkOutput("tablePlayStart", int'(play_start), 1);
            checkOutput("tableFirstSelect", int'(audio_select), int'(vecs[v].expFirst));
            checkOutput("tablePendingAfterGrant", int'(pending), int'(vecs[v].expAfterGrant));
            waitIdle();
        end

        $display("[TB] dead preempts jump");
        sbQ.push_back('{id: 1, ticks: 2});
        sbQ.push_back('{id: 2, ticks: DEAD_LEN});
        applyStimulus(3'b001);
        waitPlayTicks(1, 2);
        applyStimulus(3'b010);
        checkOutput("preemptPending", int'(pending), 2);
        cycle();
        checkOutput("preemptPlayStart", int'(play_start), 1);
        checkOutput("preemptSelect", int'(audio_select), 2);
        checkOutput("preemptPendingCleared", int'(pending), 0);
        waitIdle();

        $display("[TB] jump coalesces during win");
        sbQ.push_back('{id: 3, ticks: WIN_LEN});
        sbQ.push_back('{id: 1, ticks: JUMP_LEN});
        applyStimulus(3'b100);
        repeat (4) cycle();
        applyStimulus(3'b001);
        checkOutput("coalesceFirst", int'(pending), 1);
        cycle();
        applyStimulus(3'b001);
        checkOutput("coalesceSecond", int'(pending), 1);
        checkOutput("coalesceWinStill", int'(audio_select), 3);
        waitIdle();

        $display("[TB] mute during dead");
        sbQ.push_back('{id: 2, ticks: -1});
        applyStimulus(3'b010);
        repeat (4) cycle();
        mute = 1'b1;
        cycle();
        checkOutput("muteSelect", int'(audio_select), 0);
        checkOutput("muteBusy", int'(busy), 0);
        checkOutput("mutePending", int'(pending), 0);
        checkOutput("muteNoStart", int'(play_start), 0);
        cycle();
        applyStimulus(3'b100);
        repeat (2) cycle();
        checkOutput("mutePendingHeld", int'(pending), 0);
        mute = 1'b0;
        begin
            int savedStarts;
            savedStarts = starts;
            repeat (20) cycle();
            checkOutput("muteNoResume", starts, savedStarts);
        end
        checkOutput("muteIdleAfter", int'(busy), 0);
        checkOutput("muteScoreboardEmpty", sbQ.size(), 0);

        $display("[TB] async reset mid-play");
        sbQ.push_back('{id: 1, ticks: -1});
        applyStimulus(3'b001);
        waitPlayTicks(1, 1);
        checkOutput("preResetSelect", int'(audio_select), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncResetSelect", int'(audio_select), 0);
        checkOutput("asyncResetBusy", int'(busy), 0);
        checkOutput("asyncResetPending", int'(pending), 0);
        sbQ.delete();
        curId = 0;
        inGap = 0;
        playTicks = 0;
        #2 reset = 1'b0;
        runSingleJump();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
